// File: rtl/echo_pipe_serializer.sv
// rtl/echo_pipe_serializer.sv - portal message to header + payload word serializer.
// Optional ECHO_SER_PREFETCH_EN adds a one-entry message buffer for back-to-back headers.
module echo_pipe_serializer #(
  parameter int dataWidth = 128
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  pipe_enq_ena,
  input  logic [dataWidth+15:0] pipe_enq_v,
  output logic                  pipe_enq_rdy,
  output logic                  out_enq_ena,
  output logic [31:0]           out_enq_v,
  input  logic                  out_enq_rdy,
  output logic                  busy
);
  localparam int WORDS = dataWidth / 32;
  localparam int LW    = $clog2(WORDS + 1);

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

  state_t               state_q, state_d;
  logic [dataWidth-1:0] data_q, data_d;
  logic [LW-1:0]        len_q, len_d;
  logic [LW-1:0]        cnt_q, cnt_d;
  logic [dataWidth-1:0] in_data;
  logic [LW-1:0]        in_len;
  logic                 xfer;
  logic                 eom;

`ifdef ECHO_SER_PREFETCH_EN
  logic [dataWidth-1:0] buf_data_q, buf_data_d;
  logic [LW-1:0]        buf_len_q, buf_len_d;
  logic                 buf_v_q, buf_v_d;
`endif

  // Oversized lengths are clamped here so the header always reports what is actually sent.
  assign in_data = pipe_enq_v[dataWidth+15:16];
  assign in_len  = (pipe_enq_v[15:0] > 16'(WORDS)) ? LW'(WORDS) : pipe_enq_v[LW-1:0];

  assign xfer = out_enq_ena;
  assign eom  = xfer && (((state_q == HDR) && (len_q == '0)) ||
                         ((state_q == DATA) && (cnt_q + LW'(1) == len_q)));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pipe_enq_ena) state_d = HDR;
      HDR:     if (xfer) state_d = (len_q == '0) ? IDLE : DATA;
      DATA:    if (eom) state_d = IDLE;
      default: state_d = IDLE;
    endcase
`ifdef ECHO_SER_PREFETCH_EN
    if (eom && (buf_v_q || pipe_enq_ena)) state_d = HDR;
`endif
  end

  always_comb begin
    out_enq_ena = (state_q != IDLE) && out_enq_rdy;
    out_enq_v   = '0;
    case (state_q)
      HDR: out_enq_v = {data_q[dataWidth-1 -: 16], 16'(len_q)};
      DATA: begin
        for (int w = 0; w < WORDS; w++) begin
          if (cnt_q == LW'(w)) out_enq_v = data_q[dataWidth-1-32*w -: 32];
        end
      end
      default: out_enq_v = '0;
    endcase
`ifdef ECHO_SER_PREFETCH_EN
    pipe_enq_rdy = !RST && !buf_v_q;
    busy         = (state_q != IDLE) || buf_v_q;
`else
    pipe_enq_rdy = !RST && (state_q == IDLE);
    busy         = (state_q != IDLE);
`endif
  end

  always_comb begin
    data_d = data_q;
    len_d  = len_q;
    cnt_d  = cnt_q;
    if (state_q == HDR && xfer) cnt_d = '0;
    if (state_q == DATA && xfer) cnt_d = cnt_q + LW'(1);
`ifdef ECHO_SER_PREFETCH_EN
    buf_data_d = buf_data_q;
    buf_len_d  = buf_len_q;
    buf_v_d    = buf_v_q;
    // A message arriving exactly as msg frees bypasses the buffer.
    if (eom && buf_v_q) begin
      data_d  = buf_data_q;
      len_d   = buf_len_q;
      buf_v_d = 1'b0;
    end else if (pipe_enq_ena && (state_q == IDLE || eom)) begin
      data_d = in_data;
      len_d  = in_len;
    end else if (pipe_enq_ena) begin
      buf_data_d = in_data;
      buf_len_d  = in_len;
      buf_v_d    = 1'b1;
    end
`else
    if (pipe_enq_ena) begin
      data_d = in_data;
      len_d  = in_len;
    end
`endif
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      data_q <= '0;
      len_q  <= '0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      len_q  <= len_d;
      cnt_q  <= cnt_d;
    end
  end

`ifdef ECHO_SER_PREFETCH_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      buf_data_q <= '0;
      buf_len_q  <= '0;
      buf_v_q    <= 1'b0;
    end else begin
      buf_data_q <= buf_data_d;
      buf_len_q  <= buf_len_d;
      buf_v_q    <= buf_v_d;
    end
  end
`endif

endmodule

// File: doc/echo_pipe_serializer.md
# echo_pipe_serializer

Transmit-side counterpart of the pipe-to-method request decoder. It takes one portal message per handshake (16-bit length plus 128-bit data, the same layout the decoder consumes) and serializes it as a header word followed by up to four 32-bit payload words onto a narrow word link. It sits between an indication pipe source (method-to-pipe encoder output) and the 32-bit transport toward the host.

## Interface
Parameters:
- dataWidth, 128, payload width in bits; must be a multiple of 32; WORDS = dataWidth/32.

Ports:
- CLK  input  1  clock; all state changes on rising edge.
- RST  input  1  reset, asynchronous, active-high.
- pipe$enq__ENA  input  1  message offered and accepted this cycle; only asserted when pipe$enq__RDY=1.
- pipe$enq$v  input  dataWidth+16  message: [dataWidth+15:16] data, [15:0] length in 32-bit words.
- pipe$enq__RDY  output  1  block can accept a message this cycle.
- out$enq__ENA  output  1  word transferred this cycle.
- out$enq$v  output  32  word being transferred.
- out$enq__RDY  input  1  link can take a word this cycle.
- busy  output  1  a message is held or being serialized.

## Operation
- States: IDLE, HDR, DATA. Held message register msg plus word counter cnt (3 bits for default).
- IDLE: pipe$enq__RDY=1. On pipe$enq__ENA capture data, L = min(length, WORDS), go HDR.
- HDR: out$enq$v = {data[dataWidth-1:dataWidth-16], L[15:0]}. out$enq__ENA = out$enq__RDY. On transfer: L=0 -> end of message; else cnt=0, go DATA.
- DATA: out$enq$v = data word cnt, MSB-first (word 0 = data[dataWidth-1:dataWidth-32]). out$enq__ENA = out$enq__RDY. On transfer cnt++; after word L-1, end of message.
- End of message: go IDLE (or HDR with the buffered message, see Configuration).
- Length clamp: length > WORDS is sent as L = WORDS in the header; excess is discarded silently. length=0 sends a header-only message.
- out$enq__ENA is never asserted without out$enq__RDY. out$enq$v is held stable while a word waits for RDY.
- busy = (state != IDLE) or a buffered message exists.
- Reset (any time, including mid-message): state IDLE, buffers empty, partial message dropped, no further words of it emitted.

## Timing
- Reset values: pipe$enq__RDY=1 after RST deasserts (0 while RST high), out$enq__ENA=0, out$enq$v=0, busy=0.
- Accept on cycle N -> header offered on cycle N+1. Payload words on N+2..N+1+L when out$enq__RDY is held high.
- Each stall cycle (out$enq__RDY=0) delays all following words by one cycle. No word is lost or duplicated.
- Without prefetch: pipe$enq__RDY=0 from cycle N+1 until the cycle after the last word transfers. Back-to-back period is L+2 cycles.
- Input accept and output transfer are independent in the same cycle. There is no combinational path from pipe$enq__ENA to out$enq__ENA.

## Configuration
- ECHO_SER_PREFETCH_EN defined: adds a one-entry buffer behind msg.
  - pipe$enq__RDY = buffer empty, so the block can accept while in HDR or DATA.
  - At end of message with the buffer full, load msg from the buffer and go straight to HDR on the next cycle, so the next header directly follows the last word. Back-to-back period is L+1 cycles.
  - Accepting into the buffer in the same cycle msg frees is legal and must not lose either message.
- ECHO_SER_PREFETCH_EN undefined: single message register only; behaviour as in Timing.

## Test plan
- Basic message with out$enq__RDY=1: enq data=128'h0001_0000_AAAA_AAAA_BBBB_BBBB_CCCC_CCCC, length=2 at cycle 0 -> cycle 1 32'h0001_0002, cycle 2 32'h0001_0000, cycle 3 32'hAAAA_AAAA, then IDLE with busy=0.
- Clamp and empty: length=7 -> header low half = 4 followed by 4 words; length=0 -> header only, 32'hxxxx_0000 with id in the upper half, no data words.
- Backpressure: out$enq__RDY toggled 1,0,0,1,… during a length-4 message -> 5 words total, in order, out$enq$v stable through every stall.
- Throughput: two length-1 messages offered continuously.
  - Without the macro: second accept 3 cycles after the first.
  - With ECHO_SER_PREFETCH_EN: second header on the cycle immediately after the first message's data word.
- Reset mid-message: assert RST during DATA word 1 of a length-4 message -> outputs go to 0 asynchronously. After release pipe$enq__RDY=1, no remaining words of that message appear, and a new message serializes correctly.
